// File: rtl/ram_emu_read_port_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_emu_read_port_if
// Description : Request/response bundle between the core and the RAM emulator
//               read port.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_emu_read_port_if #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16
) ();
    logic                 req_valid;
    logic                 req_ready;
    logic [ADDR_BITS-1:0] req_addr;
    logic                 resp_valid;
    logic [DATA_BITS-1:0] resp_data;
    logic                 timeout;
    logic [1:0]           err_status;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_data, timeout, err_status
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_data, timeout, err_status
    );
endinterface
`default_nettype wire

// File: rtl/ram_emu_read_port.sv
`default_nettype none
// ============================================================================
// Module      : ram_emu_read_port
// Description : Serializes a read command onto the 2-pin link to the PIO RAM
//               emulator and deserializes the returned data word.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_emu_read_port #(
    parameter int ADDR_BITS = 16,
    parameter int DATA_BITS = 16,
    parameter int IO_BITS   = 2,
    parameter int TIMEOUT   = 255
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    ram_emu_read_port_if.slave      bus,
    output logic [IO_BITS-1:0]      tx_pins,
    input  wire logic [IO_BITS-1:0] rx_pins
);

    localparam int c_ADDR_PAIRS = ADDR_BITS / IO_BITS;
    localparam int c_DATA_PAIRS = DATA_BITS / IO_BITS;
    localparam int c_PAIRS_MAX  = (c_ADDR_PAIRS > c_DATA_PAIRS) ? c_ADDR_PAIRS : c_DATA_PAIRS;
    localparam int c_TMO_W      = $clog2(TIMEOUT + 1);
    localparam int c_PAIR_W     = ($clog2(c_PAIRS_MAX) < 1) ? 1 : $clog2(c_PAIRS_MAX);
    // One counter serves the tx pairs, the rx pairs and the response wait.
    localparam int c_CNT_W      = (c_TMO_W > c_PAIR_W) ? c_TMO_W : c_PAIR_W;

    localparam logic [c_CNT_W-1:0] c_TIMEOUT   = c_CNT_W'(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(c_ADDR_PAIRS - 1);
    localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(c_DATA_PAIRS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [IO_BITS-1:0] c_SYM_IDLE  = IO_BITS'(0);
    localparam logic [IO_BITS-1:0] c_SYM_START = IO_BITS'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TX_HDR  = 3'd1,
        S_TX_ADDR = 3'd2,
        S_WAIT_RX = 3'd3,
        S_RX_DATA = 3'd4
    } state_t;

    state_t               r_state,     w_state;
    logic [IO_BITS-1:0]   r_tx,        w_tx;
    logic [IO_BITS-1:0]   r_rx_q;
    logic [ADDR_BITS-1:0] r_addr_sr,   w_addr_sr;
    logic [DATA_BITS-1:0] r_data_sr,   w_data_sr;
    logic [DATA_BITS-1:0] r_resp_data, w_resp_data;
    logic [c_CNT_W-1:0]   r_cnt,       w_cnt;
    logic                 r_resp_valid, w_resp_valid;
    logic [1:0]           r_err,       w_err;
    logic                 w_timeout;
    logic                 w_start;
    logic                 w_bad;

    assign w_start = (r_rx_q == c_SYM_START);
    assign w_bad   = !w_start && (r_rx_q != c_SYM_IDLE);

    always_comb begin
        w_state      = r_state;
        w_tx         = r_tx;
        w_addr_sr    = r_addr_sr;
        w_data_sr    = r_data_sr;
        w_resp_data  = r_resp_data;
        w_cnt        = r_cnt;
        w_resp_valid = 1'b0;
        w_err        = r_err;
        w_timeout    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tx = c_SYM_IDLE;
                if (w_start) w_err[1] = 1'b1;
                if (bus.req_valid) begin
                    w_addr_sr = bus.req_addr;
                    w_tx      = c_SYM_START;
                    w_state   = S_TX_HDR;
                end
            end
            S_TX_HDR: begin
                if (w_start) w_err[1] = 1'b1;
                w_tx      = r_addr_sr[IO_BITS-1:0];
                w_addr_sr = r_addr_sr >> IO_BITS;
                w_cnt     = '0;
                w_state   = S_TX_ADDR;
            end
            S_TX_ADDR: begin
                if (w_start) w_err[1] = 1'b1;
                if (r_cnt == c_ADDR_LAST) begin
                    w_tx    = c_SYM_IDLE;
                    w_cnt   = '0;
                    w_state = S_WAIT_RX;
                end else begin
                    w_tx      = r_addr_sr[IO_BITS-1:0];
                    w_addr_sr = r_addr_sr >> IO_BITS;
                    w_cnt     = r_cnt + c_CNT_ONE;
                end
            end
            S_WAIT_RX: begin
                // A start symbol wins over an expiring wait in the same cycle.
                if (w_start) begin
                    w_cnt   = '0;
                    w_state = S_RX_DATA;
                end else begin
                    if (w_bad) w_err[0] = 1'b1;
                    if (r_cnt == c_TIMEOUT) begin
                        w_timeout = 1'b1;
                        w_cnt     = '0;
                        w_state   = S_IDLE;
                    end else begin
                        w_cnt = r_cnt + c_CNT_ONE;
                    end
                end
            end
            S_RX_DATA: begin
                w_data_sr = {r_rx_q, r_data_sr[DATA_BITS-1:IO_BITS]};
                if (r_cnt == c_DATA_LAST) begin
                    w_resp_data  = w_data_sr;
                    w_resp_valid = 1'b1;
                    w_cnt        = '0;
                    w_state      = S_IDLE;
                end else begin
                    w_cnt = r_cnt + c_CNT_ONE;
                end
            end
            default: begin
                w_tx    = c_SYM_IDLE;
                w_cnt   = '0;
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tx         <= '0;
            r_rx_q       <= '0;
            r_addr_sr    <= '0;
            r_data_sr    <= '0;
            r_resp_data  <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_err        <= 2'b00;
        end else begin
            r_state      <= w_state;
            r_tx         <= w_tx;
            r_rx_q       <= rx_pins;
            r_addr_sr    <= w_addr_sr;
            r_data_sr    <= w_data_sr;
            r_resp_data  <= w_resp_data;
            r_cnt        <= w_cnt;
            r_resp_valid <= w_resp_valid;
            r_err        <= w_err;
        end
    end

    assign tx_pins        = r_tx;
    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.timeout    = w_timeout;
    assign bus.err_status = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_emu_read_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_emu_read_port
// Description : Randomized self-checking bench for ram_emu_read_port with a
//               link-level emulator model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_emu_read_port;

    localparam int ADDR_BITS = 16;
    localparam int DATA_BITS = 16;
    localparam int IO_BITS   = 2;
    localparam int TIMEOUT   = 255;
    localparam int NPAIRS    = ADDR_BITS / IO_BITS;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [IO_BITS-1:0] tx_pins;
    logic [IO_BITS-1:0] rx_pins;

    ram_emu_read_port_if #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) bus ();

    ram_emu_read_port #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_BITS (DATA_BITS),
        .IO_BITS   (IO_BITS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .tx_pins (tx_pins),
        .rx_pins (rx_pins)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] err_model;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // i-th base-4 digit of a word: the i-th pair on the wire, LSB first.
    function automatic logic [1:0] pair_of(input logic [31:0] word, input int i);
        return 2'((word >> (IO_BITS * i)) % 4);
    endfunction

    // Presents a request at the current negedge and checks the command stream;
    // returns at the first cycle spent waiting for the response.
    task automatic send_request(input logic [15:0] addr);
        check_value("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 16'($urandom);
        check_value("tx_hdr", 32'(tx_pins), 32'd1);
        check_value("resp_valid_quiet", 32'(bus.resp_valid), 32'd0);
        check_value("req_ready_busy", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < NPAIRS; i++) begin
            @(negedge clk);
            check_value($sformatf("tx_addr_pair%0d", i), 32'(tx_pins), 32'(pair_of(32'(addr), i)));
        end
        @(negedge clk);
        check_value("tx_idle_after_addr", 32'(tx_pins), 32'd0);
    endtask

    task automatic run_read(input logic [15:0] addr, input logic [15:0] data,
                            input int delay, input bit bad);
        int lat;
        bit seen;
        send_request(addr);
        for (int d = 0; d < delay; d++) begin
            rx_pins = (bad && d == delay - 1) ? 2'(2 + $urandom_range(0, 1)) : 2'b00;
            @(negedge clk);
        end
        if (bad) err_model[0] = 1'b1;
        rx_pins = 2'b01;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) begin
                seen    = 1'b1;
                rx_pins = 2'b00;
            end else begin
                rx_pins = (lat <= NPAIRS) ? pair_of(32'(data), lat - 1) : 2'b00;
            end
        end
        check_value("resp_latency", 32'(lat), 32'd10);
        check_value("resp_data", 32'(bus.resp_data), 32'(data));
        check_value("req_ready_with_resp", 32'(bus.req_ready), 32'd1);
        check_value("err_status", 32'(bus.err_status), 32'(err_model));
    endtask

    initial begin
        int k;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        rx_pins       = 2'b00;
        err_model     = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("rst_tx", 32'(tx_pins), 32'd0);
        check_value("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check_value("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check_value("rst_timeout", 32'(bus.timeout), 32'd0);
        check_value("rst_resp_data", 32'(bus.resp_data), 32'd0);
        check_value("rst_err", 32'(bus.err_status), 32'd0);

        run_read(16'h1234, 16'hBEEF, 3, 1'b0);
        @(negedge clk);
        check_value("resp_pulse_end", 32'(bus.resp_valid), 32'd0);
        check_value("resp_data_hold", 32'(bus.resp_data), 32'hBEEF);

        for (int n = 0; n < 8; n++) begin
            bit b2b;
            b2b = 1'($urandom_range(0, 1));
            run_read(16'($urandom), 16'($urandom), $urandom_range(1, 20), 1'($urandom_range(0, 1)));
            if (!b2b) begin
                @(negedge clk);
                check_value("resp_pulse_end_rand", 32'(bus.resp_valid), 32'd0);
            end
        end

        // Start symbol while idle: flagged, otherwise ignored.
        rx_pins = 2'b01;
        @(negedge clk);
        rx_pins = 2'b00;
        err_model[1] = 1'b1;
        @(negedge clk);
        check_value("idle_start_no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check_value("idle_start_err", 32'(bus.err_status), 32'(err_model));
        check_value("idle_start_ready", 32'(bus.req_ready), 32'd1);

        // No response at all: the wait must expire.
        send_request(16'h0F0F);
        k = 0;
        while (!bus.timeout && k < 400) begin
            @(negedge clk);
            k++;
        end
        check_value("timeout_cycles", 32'(k), 32'(TIMEOUT));
        check_value("timeout_ready_low", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check_value("timeout_pulse_end", 32'(bus.timeout), 32'd0);
        check_value("timeout_ready_after", 32'(bus.req_ready), 32'd1);
        check_value("timeout_no_resp", 32'(bus.resp_valid), 32'd0);

        // Reset in the middle of the address phase.
        bus.req_valid = 1'b1;
        bus.req_addr  = 16'hFFFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("midrst_tx", 32'(tx_pins), 32'd0);
        check_value("midrst_err", 32'(bus.err_status), 32'd0);
        err_model = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_value("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
        check_value("midrst_no_timeout", 32'(bus.timeout), 32'd0);
        run_read(16'h8001, 16'h5A5A, 2, 1'b0);
        @(negedge clk);

        // Bad symbol while waiting, response still delivered.
        run_read(16'hA5C3, 16'h0FF0, 5, 1'b1);
        check_value("bad_sym_err", 32'(bus.err_status), 32'd1);

        // Back-to-back requests accepted in the response cycle.
        run_read(16'($urandom), 16'($urandom), 4, 1'b0);
        run_read(16'($urandom), 16'($urandom), 1, 1'b0);
        @(negedge clk);
        check_value("final_pulse_end", 32'(bus.resp_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
